expert_score_serializer: RTL

- Upstream feeder of the top-k expert selector.
- Accepts gating scores for one token from the gating matmul as wide blocks of LANES scores per handshake.
- Serializes them into one (score, expert id) pair per cycle, then holds a done window so the selector can emit its result.
- Covers NUM_EXPERTS experts per token; at most one token in flight.

---
 rtl/expert_score_serializer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/expert_score_serializer.sv
// Purpose: serializes one token's gating scores (LANES per block) into (score, expert id) pairs, then a done window.
// Latency: a block accepted at cycle t presents lane 0 at t+1; one pair per cycle after that, all outputs registered.
// Backpressure: blk_ready only in WAIT_BLK or on the last lane of a non-final block; no output-side backpressure.
module expert_score_serializer #(
  parameter int NUM_EXPERTS = 128,
  parameter int LANES       = 16,
  parameter int SCORE_W     = 16,
  parameter int ID_W        = 7,
  parameter int DONE_LEN    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [LANES*SCORE_W-1:0]   blk_scores,
  output logic                       valid_out,
  output logic [SCORE_W-1:0]         score_out,
  output logic [ID_W-1:0]            id_out,
  output logic                       done_out,
  output logic                       busy
);

  localparam int NUM_BLKS = NUM_EXPERTS / LANES;
  localparam int BLK_W    = (NUM_BLKS > 1) ? $clog2(NUM_BLKS) : 1;
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DCNT_W   = (DONE_LEN > 1) ? $clog2(DONE_LEN) : 1;

  localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'(NUM_BLKS - 1);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [DCNT_W-1:0] DONE_MAX = DCNT_W'(DONE_LEN - 1);
  // With a single lane the very first output cycle is already the last lane.
  localparam logic              ONE_LANE = (LANES == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    SERIAL   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state;
  logic [BLK_W-1:0]    blk_cnt;
  logic [LANE_W-1:0]   lane;
  logic [DCNT_W-1:0]   done_cnt;
  logic [SCORE_W-1:0]  lane_buf [LANES];

  logic [LANE_W-1:0]   lane_inc;
  logic [BLK_W-1:0]    blk_inc;

  assign lane_inc = lane + LANE_W'(1);
  assign blk_inc  = blk_cnt + BLK_W'(1);

  // Expert id = block index * LANES + lane, wrapped to the id width.
  function automatic logic [ID_W-1:0] id_of(input logic [BLK_W-1:0] b,
                                            input logic [LANE_W-1:0] l);
    return ID_W'(b) * ID_W'(LANES) + ID_W'(l);
  endfunction

  // Token FSM: block capture, lane/block counting and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      lane      <= '0;
      done_cnt  <= '0;
      blk_ready <= 1'b0;
      valid_out <= 1'b0;
      score_out <= '0;
      id_out    <= '0;
      done_out  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          done_out  <= 1'b0;
          blk_ready <= 1'b0;
          if (start) begin
            blk_cnt   <= '0;
            lane      <= '0;
            blk_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT_BLK;
          end
        end

        WAIT_BLK: begin
          valid_out <= 1'b0;
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < LANES; i++) begin
              lane_buf[i] <= blk_scores[i*SCORE_W +: SCORE_W];
            end
            lane      <= '0;
            valid_out <= 1'b1;
            score_out <= blk_scores[SCORE_W-1:0];
            id_out    <= id_of(blk_cnt, '0);
            blk_ready <= ONE_LANE && (blk_cnt < LAST_BLK);
            state     <= SERIAL;
          end
        end

        SERIAL: begin
          if (lane != LANE_MAX) begin
            // Mid-block: step to the next lane; open blk_ready one cycle
            // ahead so the next block can land on the last-lane cycle.
            lane      <= lane_inc;
            valid_out <= 1'b1;
            score_out <= lane_buf[lane_inc];
            id_out    <= id_of(blk_cnt, lane_inc);
            blk_ready <= (lane_inc == LANE_MAX) && (blk_cnt < LAST_BLK);
          end else if (blk_valid && blk_ready) begin
            // Back-to-back block: lane 0 of the new block follows with no bubble.
            for (int i = 0; i < LANES; i++) begin
              lane_buf[i] <= blk_scores[i*SCORE_W +: SCORE_W];
            end
            blk_cnt   <= blk_inc;
            lane      <= '0;
            valid_out <= 1'b1;
            score_out <= blk_scores[SCORE_W-1:0];
            id_out    <= id_of(blk_inc, '0);
            blk_ready <= ONE_LANE && (blk_inc < LAST_BLK);
          end else if (blk_cnt < LAST_BLK) begin
            // Next block not offered yet: stall in WAIT_BLK with valid_out low.
            blk_cnt   <= blk_inc;
            valid_out <= 1'b0;
            blk_ready <= 1'b1;
            state     <= WAIT_BLK;
          end else begin
            valid_out <= 1'b0;
            blk_ready <= 1'b0;
            done_out  <= 1'b1;
            done_cnt  <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          valid_out <= 1'b0;
          blk_ready <= 1'b0;
          if (done_cnt == DONE_MAX) begin
            done_out <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            done_cnt <= done_cnt + DCNT_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          done_out  <= 1'b0;
          blk_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
